// File: rtl/uart_recv_cfg.sv
// Configurable RS232 receiver: glitch-filtered start detect, 3-sample majority vote per bit,
// optional parity and 1/2 stop bits, frames queued in a small FWFT FIFO with CTS flow control.
module uart_recv_cfg #(
  parameter int CLKS_PER_BIT = 1154,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 4,
  parameter int AFULL        = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 txd_pin,
  output logic                 ctsn_pin,
  output logic [DATA_BITS-1:0] odata,
  output logic                 operr,
  output logic                 oferr,
  output logic                 obrk,
  output logic                 ovalid,
  input  logic                 oready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  // state | meaning
  // IDLE  | waiting for txd low
  // START | validating start bit at mid-bit
  // DATA  | shifting data bits, LSB first
  // PAR   | checking parity bit
  // STOP  | checking stop bit(s), push on last decision
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [TW-1:0] T_S0   = TW'(HALF - 1);
  localparam logic [TW-1:0] T_S1   = TW'(HALF);
  localparam logic [TW-1:0] T_DEC  = TW'(HALF + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 3;

  logic                 sync1, txd;
  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic                 s0, s1, vote, dec;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr, frame_ferr;
  logic                 push_req, push_ok, pop, full;
  logic [EW-1:0]        frame;
  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      txd   <= 1'b1;
    end else begin
      sync1 <= txd_pin;
      txd   <= sync1;
    end
  end

  assign dec        = (timer == T_DEC);
  assign vote       = (s0 & s1) | (s0 & txd) | (s1 & txd);
  assign frame_ferr = ferr | ~vote;
  assign push_req   = (state == S_STOP) && dec && (bit_cnt == 4'(STOP_BITS - 1));
  assign frame      = {(shreg == '0) && frame_ferr, frame_ferr, perr, shreg};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      timer   <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (timer == T_S0) s0 <= txd;
      if (timer == T_S1) s1 <= txd;
      if (state == S_IDLE) begin
        timer <= '0;
        if (!txd) begin
          state   <= S_START;
          bit_cnt <= '0;
          perr    <= 1'b0;
          ferr    <= 1'b0;
        end
      end else begin
        timer <= (timer == T_LAST) ? '0 : timer + 1'b1;
        if (dec) begin
          case (state)
            S_START: begin
              if (vote) begin
                state <= S_IDLE;
                timer <= '0;
              end else begin
                state <= S_DATA;
              end
            end
            S_DATA: begin
              shreg <= {vote, shreg[DATA_BITS-1:1]};
              if (bit_cnt == 4'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            S_PAR: begin
              perr  <= ((^shreg) ^ vote) != (PARITY == 1);
              state <= S_STOP;
            end
            S_STOP: begin
              ferr <= frame_ferr;
              // returning to IDLE on the push cycle leaves half a bit to resync on the next start
              if (bit_cnt == 4'(STOP_BITS - 1)) begin
                state <= S_IDLE;
                timer <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign ovalid  = (count != '0);
  assign pop     = ovalid & oready;
  assign full    = (count == CW'(DEPTH));
  // a pop on a full FIFO frees the slot for a same-cycle push
  assign push_ok = push_req & (~full | pop);
  assign {obrk, oferr, operr, odata} = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      ctsn_pin <= 1'b1;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= frame;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop) count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push_req && !push_ok) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      ctsn_pin <= (count >= CW'(AFULL));
    end
  end

endmodule

// File: tb/tb_uart_recv_cfg.sv
// Directed bench for uart_recv_cfg: table of single frames plus hand-written
// sequences for glitch, flow control/overrun and mid-frame reset.
module tb_uart_recv_cfg;
  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       txd_pin = 1'b1;
  logic       oready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       ctsn_pin, operr, oferr, obrk, ovalid, overrun;
  logic [7:0] odata;

  int   n_cmp = 0;
  int   n_err = 0;
  int   idx;
  logic v_trace [0:176];
  logic c_trace [0:176];

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;
  vec_t vecs [6];

  always #5 clock = ~clock;

  uart_recv_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4), .AFULL(3)
  ) dut (
    .clock(clock), .resetn(resetn), .txd_pin(txd_pin), .ctsn_pin(ctsn_pin),
    .odata(odata), .operr(operr), .oferr(oferr), .obrk(obrk), .ovalid(ovalid),
    .oready(oready), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    txd_pin = b;
    repeat (CPB) begin
      @(negedge clock);
      idx++;
      v_trace[idx] = ovalid;
      c_trace[idx] = ctsn_pin;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    idx = 0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    txd_pin = 1'b1;
  endtask

  task automatic idle(input int n);
    txd_pin = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic pop_one();
    oready = 1'b1;
    @(negedge clock);
    oready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] c3;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hFE, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clock);
    check("rst_ctsn", ctsn_pin, 1);
    check("rst_ovalid", ovalid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_odata", odata, 0);
    check("rst_flags", {operr, oferr, obrk}, 0);
    resetn = 1'b1;
    idle(20);
    check("idle_ctsn", ctsn_pin, 0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      check("push_lat_before", v_trace[172], 0);
      check("push_lat_after", v_trace[173], 1);
      idle(32);
      check("vec_ovalid", ovalid, 1);
      check("vec_odata", odata, vecs[v].exp_data);
      check("vec_operr", operr, vecs[v].exp_perr);
      check("vec_oferr", oferr, vecs[v].exp_ferr);
      check("vec_obrk", obrk, vecs[v].exp_brk);
      idle(5);
      check("vec_hold_odata", odata, vecs[v].exp_data);
      pop_one();
      check("vec_empty", ovalid, 0);
    end

    // glitch rejection
    txd_pin = 1'b0;
    repeat (4) @(negedge clock);
    idle(48);
    check("glitch_no_push", ovalid, 0);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(16);
    check("glitch_next_valid", ovalid, 1);
    check("glitch_next_data", odata, 8'h55);
    check("glitch_next_flags", {operr, oferr, obrk}, 0);
    pop_one();
    check("glitch_empty", ovalid, 0);

    // flow control and overrun
    for (int k = 1; k <= 5; k++) begin
      d = 8'h11 * k[7:0];
      send_frame(d, ^d, 1'b1);
      if (k == 3) begin
        check("cts_at_push", c_trace[173], 0);
        check("cts_after_push", c_trace[174], 1);
      end
      if (k == 4) check("no_overrun_yet", overrun, 0);
    end
    idle(32);
    check("overrun_set", overrun, 1);
    check("full_ctsn", ctsn_pin, 1);
    for (int i = 0; i < 4; i++) begin
      d = 8'h11 * 8'(i + 1);
      check("drain_valid", ovalid, 1);
      check("drain_data", odata, d);
      pop_one();
      check("cts_lag", ctsn_pin, (4 - i) >= 3);
      @(negedge clock);
      check("cts_post", ctsn_pin, (3 - i) >= 3);
    end
    check("drain_empty", ovalid, 0);
    check("overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    check("overrun_clr", overrun, 0);

    // reset mid-frame with a break entry pending
    send_frame(8'h00, 1'b0, 1'b0);
    idle(32);
    check("pre_rst_valid", ovalid, 1);
    check("pre_rst_brk", obrk, 1);
    c3 = 8'hC3;
    idx = 0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    txd_pin = c3[4];
    repeat (8) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("mid_rst_ctsn", ctsn_pin, 1);
    check("mid_rst_ovalid", ovalid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_odata", odata, 0);
    check("mid_rst_flags", {operr, oferr, obrk}, 0);
    resetn = 1'b1;
    idle(48);
    check("post_rst_empty", ovalid, 0);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(16);
    check("post_rst_valid", ovalid, 1);
    check("post_rst_data", odata, 8'hC3);
    check("post_rst_flags", {operr, oferr, obrk}, 0);
    pop_one();
    check("post_rst_drained", ovalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
